frame_shift_buffer: RTL and testbench

- Parametrised successor of the team's m×n word shift register used to assemble neuron input vectors (Q8.24 fixed point).
- Collects M words of N bits from a valid/ready stream into one M*N-bit frame, then presents the frame on a valid/ready output.
- Adds shift direction, parallel load, synchronous clear, fill count and an optional sliding-window mode.
- Sits between the per-sample data stream and the parallel MAC array inputs.

---
 rtl/frame_shift_buffer.sv | 100 ++++++++++
 tb/tb_frame_shift_buffer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_shift_buffer.sv
// Frame shift buffer: collects M words of N bits from a valid/ready stream into
// one M*N-bit frame. Supports shift direction, parallel load, clear and sliding-window mode.
module frame_shift_buffer #(
  parameter int M     = 4,
  parameter int N     = 32,
  parameter int SLIDE = 0,
  parameter int CW    = $clog2(M + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             dir,
  input  logic             load,
  input  logic [M*N-1:0]   load_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M*N-1:0]   out_data,
  output logic [CW-1:0]    count
);

  typedef enum logic [1:0] {FILL, FULL, PRIMED} state_t;

  localparam logic [CW-1:0] COUNT_FULL = CW'(M);
  localparam logic [CW-1:0] COUNT_LAST = CW'(M - 1);

  state_t state, next_state;
  logic accept, taken;
  logic [M*N-1:0] shifted;

  assign accept = in_valid & in_ready;
  assign taken  = out_valid & out_ready;

  // With a single word there is nothing to shift, so both directions just replace it.
  generate
    if (M == 1) begin : g_single
      assign shifted = in_data;
    end else begin : g_multi
      assign shifted = dir ? {out_data[(M-1)*N-1:0], in_data}
                           : {in_data, out_data[M*N-1:N]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FILL:   if (accept && count == COUNT_LAST) next_state = FULL;
      FULL: begin
        if (taken) begin
          if (SLIDE != 0)              next_state = in_valid ? FULL : PRIMED;
          else if (accept && M == 1)   next_state = FULL;
          else                         next_state = FILL;
        end
      end
      PRIMED: if (accept) next_state = FULL;
      default: next_state = FILL;
    endcase
    if (load) next_state = FULL;
    if (clr)  next_state = FILL;
  end

  always_comb begin
    out_valid = (state == FULL);
    in_ready  = 1'b0;
    case (state)
      FILL, PRIMED: in_ready = ~load;
      FULL:         in_ready = out_ready & ~load;
      default:      in_ready = 1'b0;
    endcase
  end

  // Stale words are deliberately left in place when a block frame is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      count    <= '0;
    end else if (clr) begin
      out_data <= '0;
      count    <= '0;
    end else if (load) begin
      out_data <= load_data;
      count    <= COUNT_FULL;
    end else begin
      if (accept) out_data <= shifted;
      case (state)
        FILL: if (accept) count <= count + CW'(1);
        FULL: if (taken && SLIDE == 0) count <= accept ? CW'(1) : {CW{1'b0}};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_shift_buffer.sv
// Testbench for frame_shift_buffer: block (SLIDE=0) and sliding (SLIDE=1) instances
// share stimulus and are checked against a word-array reference model.
module tb_frame_shift_buffer;
  localparam int M  = 4;
  localparam int N  = 32;
  localparam int CW = $clog2(M + 1);

  logic clk = 1'b0;
  logic rst, clr, in_valid, dir, load, out_ready;
  logic [N-1:0]   in_data;
  logic [M*N-1:0] load_data;

  logic           rdy [2];
  logic           ov  [2];
  logic [M*N-1:0] od  [2];
  logic [CW-1:0]  cnt [2];

  logic [N-1:0] mw [2][M];
  int mc [2];
  bit mv [2];
  bit mp [2];

  int passed = 0;
  int total  = 0;

  localparam logic [M*N-1:0] FRAME_DIR0 = 128'h04000000_03000000_02000000_01000000;
  localparam logic [M*N-1:0] FRAME_DIR1 = 128'h01000000_02000000_03000000_04000000;

  always #5 clk = ~clk;

  frame_shift_buffer #(.M(M), .N(N), .SLIDE(0)) dut_block (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .dir(dir), .load(load), .load_data(load_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .count(cnt[0]));

  frame_shift_buffer #(.M(M), .N(N), .SLIDE(1)) dut_slide (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .dir(dir), .load(load), .load_data(load_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .count(cnt[1]));

  function automatic logic [M*N-1:0] mframe(int i);
    logic [M*N-1:0] f;
    for (int k = 0; k < M; k++) f[k*N +: N] = mw[i][k];
    return f;
  endfunction

  function automatic logic mrdy(int i);
    return !load && (!mv[i] || out_ready);
  endfunction

  function automatic logic [M*N+CW:0] mstate(int i);
    return {mv[i], CW'(mc[i]), mframe(i)};
  endfunction

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; mp[i] = 0; mc[i] = 0;
      for (int k = 0; k < M; k++) mw[i][k] = '0;
    end
  endtask

  // One clock edge of the reference model for instance i (1 = sliding window).
  task automatic mstep(int i, bit acc);
    if (clr) begin
      mv[i] = 0; mp[i] = 0; mc[i] = 0;
      for (int k = 0; k < M; k++) mw[i][k] = '0;
    end else if (load) begin
      for (int k = 0; k < M; k++) mw[i][k] = load_data[k*N +: N];
      mc[i] = M; mv[i] = 1; mp[i] = 0;
    end else begin
      if (acc) begin
        if (!dir) begin
          for (int k = 0; k < M-1; k++) mw[i][k] = mw[i][k+1];
          mw[i][M-1] = in_data;
        end else begin
          for (int k = M-1; k > 0; k--) mw[i][k] = mw[i][k-1];
          mw[i][0] = in_data;
        end
      end
      if (mv[i]) begin
        if (out_ready) begin
          if (i == 1) begin
            mv[i] = acc; mp[i] = !acc;
          end else begin
            mc[i] = acc ? 1 : 0;
            mv[i] = acc && (M == 1);
          end
        end
      end else if (mp[i]) begin
        if (acc) begin mv[i] = 1; mp[i] = 0; end
      end else if (acc) begin
        mc[i]++;
        if (mc[i] == M) mv[i] = 1;
      end
    end
  endtask

  task automatic tick();
    bit acc [2];
    for (int i = 0; i < 2; i++) acc[i] = in_valid && mrdy(i);
    @(posedge clk);
    for (int i = 0; i < 2; i++) mstep(i, acc[i]);
    #1;
  endtask

  task automatic feed(logic [N-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
  endtask

  task automatic do_clear();
    clr = 1'b1; in_valid = 1'b0; load = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; load = 1'b0; out_ready = 1'b0;
    dir = 1'b0; in_data = '0; load_data = '0;
    mreset();
    #12 rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({ov[i], cnt[i], od[i]} !== {(M*N+CW+1){1'b0}})
        $display("[TB] FAIL reset_state inst %0d got %h want 0", i, {ov[i], cnt[i], od[i]});
      else passed++;
      total++;
      if (rdy[i] !== 1'b1) $display("[TB] FAIL reset_ready inst %0d got %b want 1", i, rdy[i]);
      else passed++;
    end
  endtask

  task automatic test_fill(bit d, logic [M*N-1:0] want);
    do_clear();
    dir = d; out_ready = 1'b1;
    for (int k = 0; k < M; k++) begin
      feed(N'((k + 1) << 24));
      total++;
      if ({ov[0], cnt[0]} !== {k == M-1, CW'(k + 1)})
        $display("[TB] FAIL fill_count dir%0d word %0d got %b/%0d want %b/%0d",
                 d, k, ov[0], cnt[0], k == M-1, k + 1);
      else passed++;
    end
    total++;
    if (od[0] !== want) $display("[TB] FAIL fill_frame dir%0d got %h want %h", d, od[0], want);
    else passed++;
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({ov[i], cnt[i], od[i]} !== mstate(i))
        $display("[TB] FAIL fill_drain inst %0d got %h want %h", i, {ov[i], cnt[i], od[i]}, mstate(i));
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    do_clear();
    dir = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < M; k++) feed(N'((k + 1) << 24));
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h05000000;
    for (int c = 0; c < 10; c++) begin
      #1;
      total++;
      if (rdy[0] !== 1'b0) $display("[TB] FAIL bp_ready cycle %0d got %b want 0", c, rdy[0]);
      else passed++;
      tick();
      total++;
      if ({ov[0], cnt[0], od[0]} !== {1'b1, CW'(M), FRAME_DIR0})
        $display("[TB] FAIL bp_hold cycle %0d got %h want %h", c, {ov[0], cnt[0], od[0]},
                 {1'b1, CW'(M), FRAME_DIR0});
      else passed++;
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (rdy[0] !== 1'b1) $display("[TB] FAIL bp_release_ready got %b want 1", rdy[0]);
    else passed++;
    tick();
    total++;
    if ({ov[0], cnt[0]} !== {1'b0, CW'(1)})
      $display("[TB] FAIL bp_release got %b/%0d want 0/1", ov[0], cnt[0]);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({ov[i], cnt[i], od[i]} !== mstate(i))
        $display("[TB] FAIL bp_model inst %0d got %h want %h", i, {ov[i], cnt[i], od[i]}, mstate(i));
      else passed++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_slide();
    logic [M*N-1:0] want;
    do_clear();
    dir = 1'b0; out_ready = 1'b1;
    for (int w = 1; w <= 7; w++) begin
      if (w == 7) begin
        in_valid = 1'b0;
        tick();
        total++;
        if (ov[1] !== 1'b0) $display("[TB] FAIL slide_gap_valid got %b want 0", ov[1]);
        else passed++;
      end
      feed(N'(w));
      if (w >= M) begin
        for (int k = 0; k < M; k++) want[k*N +: N] = N'(w - M + 1 + k);
        total++;
        if ({ov[1], cnt[1], od[1]} !== {1'b1, CW'(M), want})
          $display("[TB] FAIL slide_frame word %0d got %h want %h", w, {ov[1], cnt[1], od[1]},
                   {1'b1, CW'(M), want});
        else passed++;
      end
    end
    total++;
    if ({ov[0], cnt[0], od[0]} !== mstate(0))
      $display("[TB] FAIL slide_block_model got %h want %h", {ov[0], cnt[0], od[0]}, mstate(0));
    else passed++;
    in_valid = 1'b0;
  endtask

  task automatic test_load();
    do_clear();
    dir = 1'b0; out_ready = 1'b1;
    feed(32'h11);
    feed(32'h22);
    total++;
    if (cnt[0] !== CW'(2)) $display("[TB] FAIL load_precount got %0d want 2", cnt[0]);
    else passed++;
    load = 1'b1; load_data = {M{32'hAAAAAAAA}}; in_valid = 1'b1; in_data = 32'h99;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (rdy[i] !== 1'b0) $display("[TB] FAIL load_ready inst %0d got %b want 0", i, rdy[i]);
      else passed++;
    end
    tick();
    load = 1'b0;
    total++;
    if ({ov[0], cnt[0], od[0]} !== {1'b1, CW'(M), {M{32'hAAAAAAAA}}})
      $display("[TB] FAIL load_frame got %h want %h", {ov[0], cnt[0], od[0]},
               {1'b1, CW'(M), {M{32'hAAAAAAAA}}});
    else passed++;
    in_valid = 1'b0;
    tick();
    total++;
    if ({ov[0], cnt[0]} !== {1'b0, CW'(0)})
      $display("[TB] FAIL load_consumed got %b/%0d want 0/0", ov[0], cnt[0]);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({ov[i], cnt[i], od[i]} !== mstate(i))
        $display("[TB] FAIL load_model inst %0d got %h want %h", i, {ov[i], cnt[i], od[i]}, mstate(i));
      else passed++;
    end
  endtask

  task automatic test_clear();
    do_clear();
    dir = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) feed(N'(32'hC0 + k));
    total++;
    if (cnt[0] !== CW'(3)) $display("[TB] FAIL clear_precount got %0d want 3", cnt[0]);
    else passed++;
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    mreset();
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({ov[i], cnt[i], od[i]} !== {(M*N+CW+1){1'b0}})
        $display("[TB] FAIL async_rst inst %0d got %h want 0", i, {ov[i], cnt[i], od[i]});
      else passed++;
    end
    #2 rst = 1'b0;
    feed(32'hD1);
    feed(32'hD2);
    clr = 1'b1; in_valid = 1'b1; in_data = 32'h77;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({ov[i], cnt[i], od[i]} !== {(M*N+CW+1){1'b0}})
        $display("[TB] FAIL sync_clr inst %0d got %h want 0", i, {ov[i], cnt[i], od[i]});
      else passed++;
    end
    for (int k = 0; k < M; k++) feed(N'((k + 1) << 24));
    total++;
    if ({ov[0], cnt[0], od[0]} !== {1'b1, CW'(M), FRAME_DIR0})
      $display("[TB] FAIL clear_refill got %h want %h", {ov[0], cnt[0], od[0]},
               {1'b1, CW'(M), FRAME_DIR0});
    else passed++;
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      dir       = 1'($urandom);
      in_data   = $urandom;
      load      = $urandom_range(0, 19) == 0;
      load_data = {$urandom, $urandom, $urandom, $urandom};
      clr       = $urandom_range(0, 39) == 0;
      #1;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (rdy[i] !== mrdy(i))
          $display("[TB] FAIL rand_ready inst %0d cycle %0d got %b want %b", i, c, rdy[i], mrdy(i));
        else passed++;
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if ({ov[i], cnt[i], od[i]} !== mstate(i))
          $display("[TB] FAIL rand_state inst %0d cycle %0d got %h want %h", i, c,
                   {ov[i], cnt[i], od[i]}, mstate(i));
        else passed++;
      end
    end
    clr = 1'b0; load = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill(1'b0, FRAME_DIR0);
    test_fill(1'b1, FRAME_DIR1);
    test_backpressure();
    test_slide();
    test_load();
    test_clear();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
